// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared constants and FSM encoding for the SNN core blocks
//                (time unit, input encoder, output layer).
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    localparam int          N_IN          = 784;
    localparam int          PIX_W         = 8;
    localparam logic [15:0] LFSR_MASK     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_RUN   = 2'd1;
    localparam logic [1:0]  ST_DRAIN = 2'd2;
    localparam logic [1:0]  ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : 16-bit right-shifting Galois LFSR (x^16+x^14+x^13+x^11+1).
//                Reset and load both restore the seed; load beats enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] q
);
    import snn_pkg::*;

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Next value: reload, single Galois step, or hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (en) begin
            q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_MASK : 16'h0000);
        end
    end

    // State register; a non-zero seed keeps the sequence off the all-zero lockup.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/input_spike_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : input_spike_encoder
//  Description : Rate encoder for the input layer. One sweep per start pulse
//                reads every pixel, compares it with the LFSR low bits and
//                writes one Bernoulli spike bit per input neuron.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_spike_encoder #(
    parameter int          N_IN      = snn_pkg::N_IN,
    parameter int          ADDR_W    = 10,
    parameter int          PIX_W     = snn_pkg::PIX_W,
    parameter logic [15:0] LFSR_SEED = snn_pkg::LFSR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_ip_nub,
    input  logic [15:0]       TU,
    output logic              pix_rd_en,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              spk_wr_en,
    output logic [ADDR_W-1:0] spk_addr,
    output logic              spk_bit,
    output logic              valid_ip_nub,
    output logic              busy,
    output logic [15:0]       spike_count
);
    import snn_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);

    state_t              state_q,       state_d;
    logic                pix_rd_en_q,   pix_rd_en_d;
    logic [ADDR_W-1:0]   pix_addr_q,    pix_addr_d;
    logic                spk_wr_en_q,   spk_wr_en_d;
    logic [ADDR_W-1:0]   spk_addr_q,    spk_addr_d;
    logic [15:0]         run_cnt_q,     run_cnt_d;
    logic [15:0]         spike_count_q, spike_count_d;
    logic                valid_q,       valid_d;
    logic                busy_q,        busy_d;

    logic                lfsr_load;
    logic [15:0]         lfsr_q;
    logic                spike_now;

    // The LFSR steps once per compare, i.e. once per spike-buffer write.
    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (LFSR_SEED),
        .en   (spk_wr_en_q),
        .q    (lfsr_q)
    );

    // pix_data is the registered image-memory output for the address issued
    // last cycle, so the compare lines up with the delayed write strobe.
    assign spike_now = spk_wr_en_q & (pix_data > lfsr_q[PIX_W-1:0]);

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_d       = state_q;
        pix_rd_en_d   = 1'b0;
        pix_addr_d    = pix_addr_q;
        spk_wr_en_d   = pix_rd_en_q;
        spk_addr_d    = pix_rd_en_q ? pix_addr_q : spk_addr_q;
        run_cnt_d     = run_cnt_q + {15'd0, spike_now};
        spike_count_d = spike_count_q;
        valid_d       = 1'b0;
        busy_d        = busy_q;
        lfsr_load     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_ip_nub) begin
                    state_d     = S_RUN;
                    pix_rd_en_d = 1'b1;
                    pix_addr_d  = '0;
                    run_cnt_d   = 16'd0;
                    busy_d      = 1'b1;
                    lfsr_load   = (TU == 16'd0);
                end
            end
            S_RUN: begin
                if (pix_addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    pix_rd_en_d = 1'b1;
                    pix_addr_d  = pix_addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Final pixel is being compared now; fold it into the result.
                state_d       = S_DONE;
                valid_d       = 1'b1;
                spike_count_d = run_cnt_q + {15'd0, spike_now};
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Register every output and counter; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pix_rd_en_q   <= 1'b0;
            pix_addr_q    <= '0;
            spk_wr_en_q   <= 1'b0;
            spk_addr_q    <= '0;
            run_cnt_q     <= 16'd0;
            spike_count_q <= 16'd0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_rd_en_q   <= pix_rd_en_d;
            pix_addr_q    <= pix_addr_d;
            spk_wr_en_q   <= spk_wr_en_d;
            spk_addr_q    <= spk_addr_d;
            run_cnt_q     <= run_cnt_d;
            spike_count_q <= spike_count_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
        end
    end

    assign pix_rd_en    = pix_rd_en_q;
    assign pix_addr     = pix_addr_q;
    assign spk_wr_en    = spk_wr_en_q;
    assign spk_addr     = spk_addr_q;
    assign spk_bit      = spike_now;
    assign valid_ip_nub = valid_q;
    assign busy         = busy_q;
    assign spike_count  = spike_count_q;

endmodule
`default_nettype wire

// File: tb/tb_input_spike_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_spike_encoder
//  Description : Self-checking bench for input_spike_encoder with an image
//                memory model and a reference spike-train model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_spike_encoder;

    localparam int NPIX = 784;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_ip_nub;
    logic [15:0] TU;
    logic        pix_rd_en;
    logic [9:0]  pix_addr;
    logic [7:0]  pix_data = 8'd0;
    logic        spk_wr_en;
    logic [9:0]  spk_addr;
    logic        spk_bit;
    logic        valid_ip_nub;
    logic        busy;
    logic [15:0] spike_count;

    input_spike_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .start_ip_nub (start_ip_nub),
        .TU           (TU),
        .pix_rd_en    (pix_rd_en),
        .pix_addr     (pix_addr),
        .pix_data     (pix_data),
        .spk_wr_en    (spk_wr_en),
        .spk_addr     (spk_addr),
        .spk_bit      (spk_bit),
        .valid_ip_nub (valid_ip_nub),
        .busy         (busy),
        .spike_count  (spike_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Image memory: registered read, data one cycle after the enable.
    logic [7:0] pix_mem [NPIX];
    always @(posedge clk) begin
        if (pix_rd_en) pix_data <= (int'(pix_addr) < NPIX) ? pix_mem[pix_addr] : 8'd0;
    end

    // Run bookkeeping owned by the stimulus block.
    int S      = -100000;
    int run_id = 0;

    // Monitor state owned by the monitor block.
    int   last_run = 0;
    int   wr_cnt = 0, exp_next = 0, order_err = 0;
    int   valid_cnt = 0, valid_cyc = 0, busy_err = 0;
    logic got_bits [NPIX];

    always @(negedge clk) begin
        if (run_id != last_run) begin
            last_run  = run_id;
            wr_cnt    = 0;
            exp_next  = 0;
            order_err = 0;
            valid_cnt = 0;
            valid_cyc = 0;
            busy_err  = 0;
            for (int a = 0; a < NPIX; a++) got_bits[a] = 1'bx;
        end
        if (spk_wr_en) begin
            if (spk_addr != 10'(exp_next) || cyc != S + 2 + exp_next) order_err++;
            if (int'(spk_addr) < NPIX) got_bits[spk_addr] = spk_bit;
            exp_next++;
            wr_cnt++;
        end
        if (valid_ip_nub) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
        if (cyc >= S + 1 && cyc <= S + 786 && busy !== 1'b1) busy_err++;
    end

    // Reference model state and results.
    logic [15:0] model_lfsr = 16'hACE1;
    logic        exp_bits [NPIX];
    int          exp_count;
    logic        vec_a [NPIX];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected spike vector: each pixel against the current LFSR low byte,
    // then one Galois step per pixel.
    task automatic build_model(input logic [15:0] tu);
        if (tu == 16'd0) model_lfsr = 16'hACE1;
        exp_count = 0;
        for (int a = 0; a < NPIX; a++) begin
            exp_bits[a] = (pix_mem[a] > model_lfsr[7:0]);
            if (exp_bits[a]) exp_count++;
            model_lfsr = (model_lfsr >> 1) ^ (model_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    task automatic start_pulse(input logic [15:0] tu);
        run_id++;
        S = cyc + 1;
        tick();
        start_ip_nub = 1'b1;
        TU           = tu;
    endtask

    function automatic int bit_diffs();
        int n = 0;
        for (int a = 0; a < NPIX; a++) if (got_bits[a] !== exp_bits[a]) n++;
        return n;
    endfunction

    task automatic do_run(input logic [15:0] tu, input string tag, input bit extra);
        build_model(tu);
        start_pulse(tu);
        while (cyc < S + 795) begin
            tick();
            start_ip_nub = extra && (cyc == S + 1 || cyc == S + 400 || cyc == S + 786);
            TU = extra ? 16'd0 : tu;
        end
        start_ip_nub = 1'b0;
        chk({tag, " write_count"},  64'(wr_cnt),          64'd784);
        chk({tag, " write_order"},  64'(order_err),       64'd0);
        chk({tag, " valid_pulses"}, 64'(valid_cnt),       64'd1);
        chk({tag, " valid_cycle"},  64'(valid_cyc - S),   64'd786);
        chk({tag, " busy_in_sweep"},64'(busy_err),        64'd0);
        chk({tag, " spike_bits"},   64'(bit_diffs()),     64'd0);
        chk({tag, " spike_count"},  64'(spike_count),     64'(exp_count));
        chk({tag, " idle_after"},   {62'd0, busy, pix_rd_en}, 64'd0);
    endtask

    function automatic logic [63:0] out_vec();
        return {23'd0, pix_rd_en, pix_addr, spk_wr_en, spk_addr, spk_bit,
                valid_ip_nub, busy, spike_count};
    endfunction

    initial begin
        rst          = 1'b1;
        start_ip_nub = 1'b0;
        TU           = 16'd0;
        repeat (3) tick();
        chk("reset_outputs", out_vec(), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_outputs", out_vec(), 64'd0);

        // All-255 image from the seed.
        for (int a = 0; a < NPIX; a++) pix_mem[a] = 8'd255;
        do_run(16'd0, "all255", 1'b0);

        // All-zero image, no reload.
        for (int a = 0; a < NPIX; a++) pix_mem[a] = 8'd0;
        do_run(16'd5, "all0", 1'b0);
        chk("all0 zero_count", 64'(spike_count), 64'd0);

        // Seed reload determinism on a random image.
        for (int a = 0; a < NPIX; a++) pix_mem[a] = 8'($urandom);
        do_run(16'd0, "rand_tu0_a", 1'b0);
        for (int a = 0; a < NPIX; a++) vec_a[a] = got_bits[a];
        do_run(16'd0, "rand_tu0_b", 1'b0);
        begin
            int d = 0;
            for (int a = 0; a < NPIX; a++) if (got_bits[a] !== vec_a[a]) d++;
            chk("reload_identical", 64'(d), 64'd0);
        end
        do_run(16'd1, "rand_tu1", 1'b0);
        begin
            int d = 0;
            for (int a = 0; a < NPIX; a++) if (got_bits[a] !== vec_a[a]) d++;
            chk("continue_differs", 64'(d != 0), 64'd1);
        end

        // Start pulses while busy must be ignored.
        for (int a = 0; a < NPIX; a++) pix_mem[a] = 8'($urandom);
        do_run(16'd0, "extra_starts", 1'b1);

        // Reset in the middle of a sweep, then a clean restart without reload.
        start_pulse(16'd3);
        while (cyc < S + 300) begin
            tick();
            start_ip_nub = 1'b0;
        end
        rst = 1'b1;
        tick();
        chk("midreset_outputs", out_vec(), 64'd0);
        rst = 1'b0;
        chk("midreset_writes", 64'(wr_cnt), 64'd299);
        while (cyc < S + 309) tick();
        chk("midreset_no_valid", 64'(valid_cnt), 64'd0);
        model_lfsr = 16'hACE1;
        do_run(16'd7, "after_reset", 1'b0);

        // Ramp image.
        for (int a = 0; a < NPIX; a++) pix_mem[a] = 8'(a % 256);
        do_run(16'd0, "ramp", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_spike_encoder.md
# input_spike_encoder

Input-layer rate encoder for the SNN core. On each `start_ip_nub` pulse from the time unit, it sweeps all input pixels of the current image. Each 8-bit intensity is compared against a 16-bit LFSR value to produce one Bernoulli spike bit per input neuron, and the spike bits are written into the input spike buffer. When the sweep finishes, it returns a single-cycle `valid_ip_nub` so the time unit can advance to the output-layer update.

## Interface
- `N_IN`, 784: number of input neurons/pixels per image.
- `ADDR_W`, 10: pixel/spike address width; must satisfy 2^ADDR_W >= N_IN.
- `PIX_W`, 8: pixel intensity width; must be <= 16.
- `LFSR_SEED`, 16'hACE1: LFSR reload value; must be non-zero.

- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `start_ip_nub`, input, 1: one-cycle start pulse from the time unit.
- `TU`, input, 16: current time-unit index, sampled with `start_ip_nub`.
- `pix_rd_en`, output, 1: image memory read enable.
- `pix_addr`, output, ADDR_W: image memory read address.
- `pix_data`, input, PIX_W: read data, valid exactly 1 cycle after `pix_rd_en`.
- `spk_wr_en`, output, 1: spike buffer write enable.
- `spk_addr`, output, ADDR_W: spike buffer write address.
- `spk_bit`, output, 1: spike value written.
- `valid_ip_nub`, output, 1: one-cycle done pulse to the time unit.
- `busy`, output, 1: high from the cycle after start until the cycle `valid_ip_nub` is high, inclusive.
- `spike_count`, output, 16: spikes generated in the last completed sweep.

## Operation
- FSM states:
  - IDLE: waits for `start_ip_nub`.
  - RUN: issues reads for addresses 0..N_IN-1.
  - DRAIN: compares the final pixel.
  - DONE: pulses `valid_ip_nub` and returns to IDLE.
- IDLE + `start_ip_nub`:
  - Go to RUN, clear the address counter and the running spike counter.
  - If `TU == 0`, reload the LFSR with LFSR_SEED. This makes the per-image spike trains deterministic.
- RUN: each cycle, `pix_rd_en=1`, `pix_addr=cnt`, `cnt++`. After issuing `N_IN-1`, go to DRAIN.
- Compare stage runs one cycle behind the read stage:
  - `spk_bit = (pix_data > lfsr[PIX_W-1:0])`.
  - `spk_addr` = delayed address, `spk_wr_en=1`.
  - LFSR advances once per compare.
  - Running count increments when `spk_bit=1`.
- LFSR: 16-bit Galois, right-shift, mask 16'hB400 (x^16+x^14+x^13+x^11+1). It never reaches zero.
- Pixel 0 never spikes. Pixel 255 spikes unless the LFSR low byte is 255.
- DONE: `valid_ip_nub=1` for one cycle. `spike_count` is loaded from the running counter, then holds until the next DONE. Next state is IDLE.
- `start_ip_nub` while not in IDLE is ignored: no restart and no error.
- TU is otherwise unused; no TU arithmetic is done here.

## Timing
- Reset values:
  - State IDLE; all counters 0; LFSR = LFSR_SEED.
  - `pix_rd_en`, `spk_wr_en`, `valid_ip_nub`, `busy`, `spk_bit` = 0.
  - `pix_addr`, `spk_addr`, `spike_count` = 0.
- Start sampled in cycle S:
  - Reads are issued in cycles S+1..S+N_IN.
  - Writes occur in cycles S+2..S+N_IN+1, one per cycle, addresses ascending with no gaps.
  - `valid_ip_nub` is high in cycle S+N_IN+2.
  - Total latency is N_IN+2 cycles.
- Next accepted start: earliest in cycle S+N_IN+3, when the FSM is back in IDLE.
- `spike_count` is updated in the same cycle as `valid_ip_nub`; it includes the final compare.
- Reset asserted mid-sweep:
  - Next cycle shows all reset values.
  - Any pending write is dropped, and `valid_ip_nub` is not produced.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package `snn_pkg`:
  - FSM state encoding as a localparam (2-bit).
  - Constants: `N_IN`, `PIX_W`, `LFSR_MASK` = 16'hB400, `LFSR_SEED_DEF` = 16'hACE1.
  - Shared with the time unit and the output-layer block.
- One sub-module, `lfsr16`:
  - Ports: `clk`, `rst`, `load`, `seed`, `en`, `q`.
  - Synchronous reset to seed; `load` has priority over `en`.
  - Reused later by the output-layer noise injection.

## Test plan
- Reset, then start with TU=0; the memory model returns 255 for all pixels.
  - Required: writes occur at addresses 0..783.
  - Required: `spk_bit` is 1 except where the LFSR low byte equals 255.
  - Required: `valid_ip_nub` is high at S+786.
  - Required: `spike_count` equals the golden LFSR model's count.
- All pixels 0, TU=5 → 784 writes with `spk_bit=0`, `spike_count=0`, and one `valid_ip_nub` pulse.
- Two runs, each started at TU=0 with identical pixel data → identical spike vectors, confirming the seed reload. With TU=1 on the second run, the vector continues the LFSR sequence and differs.
- Extra start pulses in cycles S+1, S+400 and S+786 → ignored. Exactly 784 writes and one `valid_ip_nub` occur, and `busy` stays high throughout the sweep.
- Reset asserted at S+300 → next cycle all outputs are 0 and the LFSR equals 16'hACE1. No `valid_ip_nub` follows. A new start at S+310 completes normally.
- Pixel ramp `addr mod 256` against the golden model → all 784 `spk_bit` values and `spike_count` match exactly, with write order strictly ascending.
